// File: rtl/audio_gain_ramp_nch.sv
// Multi-channel gain stage: one shared gain per frame, applied through a single
// time-multiplexed multiplier, ramped one step per frame, saturated per channel.
module audio_gain_ramp_nch #(
   parameter int NCH       = 2,
   parameter int DW        = 24,
   parameter int GW        = 9,
   parameter int GFRAC     = 5,
   parameter int RAMP_STEP = 1
) (
   input  logic              MCLK_i,
   input  logic              nRST_i,
   input  logic [GW-1:0]     GAIN_TARGET_i,
   input  logic              MUTE_i,
   input  logic [NCH*DW-1:0] PDATA_i,
   input  logic              PDATA_VALID_i,
   output logic [NCH*DW-1:0] PDATA_o,
   output logic              PDATA_VALID_o,
   output logic [NCH-1:0]    CLIP_o,
   output logic              DROP_o,
   output logic              RAMP_ACTIVE_o
);

   localparam int PW = DW + GW + 1;
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [GW-1:0] STEP = GW'(RAMP_STEP);
   localparam logic signed [PW-1:0] Q_MAX = {{(GW+2){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [PW-1:0] Q_MIN = {{(GW+2){1'b1}}, {(DW-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, MUL, SAT} state_e;

   state_e              state_q, state_d;
   logic [CW-1:0]       ch_q, ch_d, p_ch_q;
   logic                p_vld_q;
   logic [NCH*DW-1:0]   frame_q;
   logic [GW-1:0]       g_use_q, g_cur_q, g_cur_d;
   logic signed [PW-1:0] p_q, p_d;
   logic [NCH*DW-1:0]   acc_q, acc_d;
   logic [NCH-1:0]      acc_clip_q, acc_clip_d;
   logic [NCH*DW-1:0]   pdata_q;
   logic [NCH-1:0]      clip_q;
   logic                vld_q, drop_q, ramp_q;

   logic                accept, mul_en, emit;
   logic [GW-1:0]       target;
   logic signed [DW-1:0] sample;
   logic signed [GW:0]  gain_s;
   logic signed [PW-1:0] q_full;
   logic [DW-1:0]       sat_val;
   logic                sat_clip;

   assign accept = (state_q == IDLE) && PDATA_VALID_i;
   assign target = MUTE_i ? '0 : GAIN_TARGET_i;

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      mul_en  = 1'b0;
      emit    = 1'b0;
      case (state_q)
         IDLE: if (PDATA_VALID_i) begin
            state_d = MUL;
            ch_d    = '0;
         end
         MUL: begin
            mul_en = 1'b1;
            if (ch_q == CW'(NCH - 1)) state_d = SAT;
            else                      ch_d    = ch_q + 1'b1;
         end
         SAT: begin
            emit    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Step toward the target without overshooting; only accepted frames move the gain.
   always_comb begin
      g_cur_d = g_cur_q;
      if (accept) begin
         if (target > g_cur_q)
            g_cur_d = ((target - g_cur_q) > STEP) ? g_cur_q + STEP : target;
         else if (target < g_cur_q)
            g_cur_d = ((g_cur_q - target) > STEP) ? g_cur_q - STEP : target;
      end
   end

   assign sample = frame_q[ch_q*DW +: DW];
   assign gain_s = {1'b0, g_use_q};
   assign p_d    = PW'(sample) * PW'(gain_s);

   // Saturation works on the product registered in the previous cycle.
   assign q_full = p_q >>> GFRAC;
   always_comb begin
      sat_val  = q_full[DW-1:0];
      sat_clip = 1'b0;
      if (q_full > Q_MAX) begin
         sat_val  = {1'b0, {(DW-1){1'b1}}};
         sat_clip = 1'b1;
      end else if (q_full < Q_MIN) begin
         sat_val  = {1'b1, {(DW-1){1'b0}}};
         sat_clip = 1'b1;
      end
   end

   always_comb begin
      acc_d      = acc_q;
      acc_clip_d = acc_clip_q;
      if (p_vld_q) begin
         acc_d[p_ch_q*DW +: DW] = sat_val;
         acc_clip_d[p_ch_q]     = sat_clip;
      end
   end

   // NOTE: data registers are reset too, so outputs read 0 immediately and no stale frame leaks.
   always_ff @(posedge MCLK_i or negedge nRST_i) begin
      if (!nRST_i) begin
         state_q    <= IDLE;
         ch_q       <= '0;
         p_ch_q     <= '0;
         p_vld_q    <= 1'b0;
         frame_q    <= '0;
         g_use_q    <= '0;
         g_cur_q    <= '0;
         p_q        <= '0;
         acc_q      <= '0;
         acc_clip_q <= '0;
         pdata_q    <= '0;
         clip_q     <= '0;
         vld_q      <= 1'b0;
         drop_q     <= 1'b0;
         ramp_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ch_q       <= ch_d;
         p_ch_q     <= ch_q;
         p_vld_q    <= mul_en;
         g_cur_q    <= g_cur_d;
         acc_q      <= acc_d;
         acc_clip_q <= acc_clip_d;
         vld_q      <= emit;
         drop_q     <= PDATA_VALID_i && (state_q != IDLE);
         ramp_q     <= (g_cur_d != target);
         if (accept) begin
            frame_q <= PDATA_i;
            g_use_q <= g_cur_q;
         end
         if (mul_en) p_q <= p_d;
         if (emit) begin
            pdata_q <= acc_d;
            clip_q  <= acc_clip_d;
         end
      end
   end

   assign PDATA_o       = pdata_q;
   assign PDATA_VALID_o = vld_q;
   assign CLIP_o        = clip_q;
   assign DROP_o        = drop_q;
   assign RAMP_ACTIVE_o = ramp_q;

endmodule

// File: tb/tb_audio_gain_ramp_nch.sv
// Directed bench: a stereo unit-step instance and a six-channel fast-ramp instance
// share clock and reset; expected values are hand-derived constants.
module tb_audio_gain_ramp_nch;

   localparam int DW = 24;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [8:0]      g0, g1;
   logic            m0, m1;
   logic [2*DW-1:0] pd0_i, pd0_o;
   logic [6*DW-1:0] pd1_i, pd1_o;
   logic            v0_i, v0_o, v1_i, v1_o;
   logic [1:0]      clip0;
   logic [5:0]      clip1;
   logic            drop0, drop1, ramp0, ramp1;

   int checks = 0;
   int errors = 0;

   audio_gain_ramp_nch #(.NCH(2)) u_dut0 (
      .MCLK_i(clk), .nRST_i(rst_n), .GAIN_TARGET_i(g0), .MUTE_i(m0),
      .PDATA_i(pd0_i), .PDATA_VALID_i(v0_i), .PDATA_o(pd0_o),
      .PDATA_VALID_o(v0_o), .CLIP_o(clip0), .DROP_o(drop0), .RAMP_ACTIVE_o(ramp0)
   );

   audio_gain_ramp_nch #(.NCH(6), .RAMP_STEP(127)) u_dut1 (
      .MCLK_i(clk), .nRST_i(rst_n), .GAIN_TARGET_i(g1), .MUTE_i(m1),
      .PDATA_i(pd1_i), .PDATA_VALID_i(v1_i), .PDATA_o(pd1_o),
      .PDATA_VALID_o(v1_o), .CLIP_o(clip1), .DROP_o(drop1), .RAMP_ACTIVE_o(ramp1)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Drives one frame at the current negedge and waits (bounded) for its output.
   task automatic send0(input logic [23:0] c0, input logic [23:0] c1,
                        output logic [2*DW-1:0] o, output logic [1:0] cl, output int lat);
      pd0_i = {c1, c0};
      v0_i  = 1'b1;
      @(negedge clk);
      v0_i = 1'b0;
      lat  = 1;
      while (v0_o !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      o  = pd0_o;
      cl = clip0;
   endtask

   task automatic send1(input logic [6*DW-1:0] fin,
                        output logic [6*DW-1:0] o, output logic [5:0] cl, output int lat);
      pd1_i = fin;
      v1_i  = 1'b1;
      @(negedge clk);
      v1_i = 1'b0;
      lat  = 1;
      while (v1_o !== 1'b1 && lat < 30) begin
         @(negedge clk);
         lat++;
      end
      o  = pd1_o;
      cl = clip1;
   endtask

   // Stereo frame of +/-0x100000 whose expected output is +/-gain*0x8000.
   task automatic frame_pm(input string tag, input int gain);
      logic [2*DW-1:0] o;
      logic [1:0]      cl;
      int              lat;
      logic [23:0]     ep, en;
      ep = 24'(gain * 32'h8000);
      en = 24'(-(gain * 32'h8000));
      send0(24'hF00000, 24'h100000, o, cl, lat);
      check({tag, "_lat"}, 64'(lat), 64'd4);
      check({tag, "_ch1"}, 64'(o[47:24]), 64'(ep));
      check({tag, "_ch0"}, 64'(o[23:0]), 64'(en));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [2*DW-1:0] o0;
      logic [1:0]      cl0;
      logic [6*DW-1:0] o1, f1;
      logic [5:0]      cl1;
      int              lat;
      int              seen;

      rst_n = 1'b0;
      g0 = '0; g1 = '0; m0 = 1'b0; m1 = 1'b0;
      pd0_i = '0; pd1_i = '0; v0_i = 1'b0; v1_i = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_pdata", 64'(pd0_o), 64'd0);
      check("rst_valid", 64'(v0_o), 64'd0);
      check("rst_clip", 64'(clip0), 64'd0);
      check("rst_drop", 64'(drop0), 64'd0);
      check("rst_ramp", 64'(ramp0), 64'd0);
      rst_n = 1'b1;
      g0 = 9'd32;
      @(negedge clk);
      check("ramp_active_start", 64'(ramp0), 64'd1);

      // Unit-step ramp: frame n applies gain n.
      for (int n = 0; n <= 32; n++) begin
         frame_pm($sformatf("ramp%0d", n), n);
         if (n == 30) check("ramp_active_f30", 64'(ramp0), 64'd1);
         if (n == 31) check("ramp_active_f31", 64'(ramp0), 64'd0);
      end
      check("ramp_active_end", 64'(ramp0), 64'd0);

      // Busy drop and back-to-back accept at unity gain.
      pd0_i = {24'h123456, 24'hFEDCBA};
      v0_i  = 1'b1;
      @(negedge clk);                      // cycle 1
      v0_i = 1'b0;
      @(negedge clk);                      // cycle 2
      pd0_i = {24'h7FFFFF, 24'h7FFFFF};
      v0_i  = 1'b1;
      @(negedge clk);                      // cycle 3
      v0_i = 1'b0;
      check("drop_c3", 64'(drop0), 64'd1);
      check("valid_c3", 64'(v0_o), 64'd0);
      @(negedge clk);                      // cycle 4
      check("valid_c4", 64'(v0_o), 64'd1);
      check("drop_c4", 64'(drop0), 64'd0);
      check("data_c4", 64'(pd0_o), 64'h123456FEDCBA);
      pd0_i = {24'h000020, 24'hFFFFE0};
      v0_i  = 1'b1;
      @(negedge clk);                      // cycle 5
      v0_i = 1'b0;
      check("valid_c5", 64'(v0_o), 64'd0);
      check("hold_c5", 64'(pd0_o), 64'h123456FEDCBA);
      seen = 0;
      repeat (2) begin
         @(negedge clk);
         if (v0_o) seen++;
      end
      check("no_extra_out", 64'(seen), 64'd0);
      @(negedge clk);                      // cycle 8
      check("valid_c8", 64'(v0_o), 64'd1);
      check("data_c8", 64'(pd0_o), 64'h000020FFFFE0);

      // Mute ramps the applied gain 32 down to 0, then stays silent.
      m0 = 1'b1;
      for (int k = 0; k <= 32; k++) begin
         frame_pm($sformatf("mute%0d", k), 32 - k);
         if (k == 30) check("mute_ramp_f30", 64'(ramp0), 64'd1);
      end
      frame_pm("muted_a", 0);
      frame_pm("muted_b", 0);
      check("mute_ramp_end", 64'(ramp0), 64'd0);
      m0 = 1'b0;
      @(negedge clk);
      check("unmute_ramp", 64'(ramp0), 64'd1);
      for (int k = 0; k < 4; k++) frame_pm($sformatf("unmute%0d", k), k);

      // Saturation on the six-channel instance, gain step 127.
      g1 = 9'd127;
      send1('0, o1, cl1, lat);
      check("sat0_lat", 64'(lat), 64'd8);
      f1 = '0;
      f1[23:0]  = 24'h800000;
      f1[47:24] = 24'h7FFFFF;
      send1(f1, o1, cl1, lat);
      check("sat_ch0", 64'(o1[23:0]), 64'h800000);
      check("sat_ch1", 64'(o1[47:24]), 64'h7FFFFF);
      check("sat_clip", 64'(cl1), 64'h03);
      g1 = 9'd16;
      f1 = '0;
      f1[23:0] = 24'h000100;
      send1(f1, o1, cl1, lat);
      check("g127_ch0", 64'(o1[23:0]), 64'h0003F8);
      check("g127_clip", 64'(cl1), 64'h00);

      // Floor rounding at gain 16 (half scale).
      f1 = '0;
      f1[23:0]  = 24'hFFFFFF;
      f1[47:24] = 24'h000001;
      f1[71:48] = 24'hFFFFFD;
      send1(f1, o1, cl1, lat);
      check("floor_m1", 64'(o1[23:0]), 64'hFFFFFF);
      check("floor_p1", 64'(o1[47:24]), 64'h000000);
      check("floor_m3", 64'(o1[71:48]), 64'hFFFFFE);

      // Reset in cycle 2 of a frame aborts it.
      pd0_i = {24'h100000, 24'h100000};
      v0_i  = 1'b1;
      pd1_i = '1;
      v1_i  = 1'b1;
      @(negedge clk);
      v0_i = 1'b0;
      v1_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_pdata0", 64'(pd0_o), 64'd0);
      check("mid_rst_pdata1", 64'(pd1_o[63:0]), 64'd0);
      check("mid_rst_valid", 64'(v0_o), 64'd0);
      check("mid_rst_ramp", 64'(ramp0), 64'd0);
      check("mid_rst_clip", 64'(clip1), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (v0_o || v1_o) seen++;
      end
      check("aborted_no_out", 64'(seen), 64'd0);
      frame_pm("post_rst0", 0);
      frame_pm("post_rst1", 1);

      g1 = 9'd32;
      f1 = {24'h800000, 24'h7FFFFF, 24'hEDCBA0, 24'h123456, 24'hFFFFF0, 24'h000001};
      send1(f1, o1, cl1, lat);
      check("n6_first_zero", 64'(o1[63:0]), 64'd0);
      send1(f1, o1, cl1, lat);
      check("n6_lat", 64'(lat), 64'd8);
      for (int k = 0; k < 6; k++)
         check($sformatf("n6_ch%0d", k), 64'(o1[k*DW +: DW]), 64'(f1[k*DW +: DW]));
      check("n6_clip", 64'(cl1), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/audio_gain_ramp_nch.md
Name: audio_gain_ramp_nch

Overview:
Parametrised, multi-channel successor to the fixed stereo amplify/saturate stage in the APU path. It sits between the decimated FIR output and the I2S/SPDIF transmitters. It applies one shared gain to every channel of a frame using a single time-multiplexed multiplier. The applied gain ramps one step per frame toward the target, so volume changes, mute, unmute and reset release are pop-free. Each channel is saturated and flagged on clipping.

Parameters:
NCH, 2, channels per frame; valid range 1..8; channel k occupies PDATA bits [k*DW +: DW].
DW, 24, signed sample width, input and output.
GW, 9, unsigned gain width.
GFRAC, 5, gain fractional bits; gain 2^GFRAC is 0 dB.
RAMP_STEP, 1, maximum gain change per accepted frame; valid range 1..2^GW-1.

Ports:
MCLK_i  in  1  audio master clock; the only clock.
nRST_i  in  1  reset; asynchronous, active-low.
GAIN_TARGET_i  in  GW  target gain, unsigned.
MUTE_i  in  1  forces the effective target to 0.
PDATA_i  in  NCH*DW  input frame, signed per channel.
PDATA_VALID_i  in  1  single-cycle frame strobe.
PDATA_o  out  NCH*DW  output frame; holds its value between frames.
PDATA_VALID_o  out  1  single-cycle output strobe.
CLIP_o  out  NCH  per-channel clip flags for the current output frame.
DROP_o  out  1  single-cycle pulse: an input frame was discarded.
RAMP_ACTIVE_o  out  1  high while the current gain differs from the effective target.

Behaviour:
- Reset: every output is 0; current gain g_cur=0; FSM in IDLE. Reset takes effect immediately mid-frame, and an in-flight frame is never emitted.
- FSM states: IDLE, MUL, SAT.
- IDLE: when PDATA_VALID_i=1, latch PDATA_i and g_use=g_cur; go to MUL with channel counter ch=0.
- Ramp update on accept: T = MUTE_i ? 0 : GAIN_TARGET_i, sampled only at accept. g_cur moves toward T by min(RAMP_STEP, |T-g_cur|) and never overshoots. The gain applied to a frame is always g_use, the value before the update.
- MUL: one channel per cycle, ch=0..NCH-1. Product P = sample * {1'b0,g_use}; width DW+GW+1, registered. After ch=NCH-1, go to SAT.
- Saturation runs one cycle behind the multiply, per channel. Q = P >>> GFRAC, arithmetic, floor, no rounding. If Q > 2^(DW-1)-1, output max and set CLIP_o[ch]=1. If Q < -2^(DW-1), output min and set CLIP_o[ch]=1. Otherwise output Q[DW-1:0].
- SAT: finishes the last channel; PDATA_o and CLIP_o update together; go to IDLE.
- Latency: if the frame is sampled at cycle 0, PDATA_VALID_o is high in cycle NCH+2 only. The FSM is in IDLE in that same cycle and may accept a new frame there.
- Busy: PDATA_VALID_i in cycles 1..NCH+1 is discarded. DROP_o pulses in the following cycle; g_cur and the data path are unaffected.
- RAMP_ACTIVE_o: registered, evaluated every cycle as (g_cur != effective target of the current inputs); 0 in reset.
- Gain 0 gives exact zero output. Channel order is preserved; no channel swap is done here.

Test Plan:
1. Ramp up (default parameters), GAIN_TARGET_i=32, frames L(ch1)=0x100000, R(ch0)=-0x100000 -> frame n outputs ±0x100000*n/32 for n=0..32 (frame 0 gives 0, frame 32 gives ±0x100000). RAMP_ACTIVE_o falls once g_cur=32 after frame 31's update.
2. Saturation, RAMP_STEP=127, target 127, second frame ch1=0x7FFFFF, ch0=-0x800000 -> outputs 0x7FFFFF / 0x800000, CLIP_o=2'b11. A frame with ch0=0x000100 -> 0x0003F8, CLIP_o[0]=0.
3. Floor, gain 16 -> input -1 gives -1; input 1 gives 0; input -3 gives -2.
4. Timing, NCH=2 -> valid at cycle 0 gives PDATA_VALID_o at cycle 4. A frame at cycle 2 gives DROP_o at cycle 3 and no extra output. A frame at cycle 4 is accepted, with output at cycle 8.
5. Mute at g_cur=32 -> applied gains 32,31,...,1,0 over successive frames, then constant zero output. Unmute ramps 0->32 again.
6. Reset asserted in cycle 2 of a frame -> all outputs 0 immediately, no PDATA_VALID_o. Next frame after release uses gain 0. Repeat with NCH=6 -> latency 8, all six channels preserved in order.
